// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and default width.
package sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle between a requester (master) and the serial subtractor (slave).
interface serial_subtractor_if
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, bin,
    input  diff, bout, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, busy, done
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB first, one bit per clock.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave s
);

  // Smallest counter that can hold WIDTH-1.
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             d_bit;
  logic             brw_nxt;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (brw),
    .diff (d_bit),
    .bout (brw_nxt)
  );

  // Control FSM plus operand/result shift registers, all with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      s.diff <= '0;
      s.bout <= 1'b0;
      s.busy <= 1'b0;
      s.done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s.start) begin
            a_sr   <= s.a;
            b_sr   <= s.b;
            brw    <= s.bin;
            cnt    <= '0;
            s.busy <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          brw    <= brw_nxt;
          s.diff <= {d_bit, s.diff[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // Last bit: publish the final borrow and hand over to DONE.
            cnt    <= '0;
            s.bout <= brw_nxt;
            s.busy <= 1'b0;
            s.done <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          s.done <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          s.busy <= 1'b0;
          s.done <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  serial_subtractor_if #(.WIDTH(W)) ifc ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full operation: accept, WIDTH busy cycles, one done cycle, back to idle.
  // glitch=1 pulses start with new operands in the middle of SHIFT.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input logic [W-1:0] exp_d, input logic exp_bo,
                        input bit glitch);
    ifc.a = a; ifc.b = b; ifc.bin = bin; ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
    ifc.a = ~a; ifc.b = a ^ b; ifc.bin = ~bin;
    for (int i = 0; i < W; i++) begin
      chk({tag, ".busy"}, 32'(ifc.busy), 32'd1);
      chk({tag, ".nodone"}, 32'(ifc.done), 32'd0);
      if (glitch && i == 2) begin
        ifc.a = 8'd1; ifc.b = 8'd2; ifc.bin = 1'b0; ifc.start = 1'b1;
      end else begin
        ifc.start = 1'b0;
      end
      step();
    end
    ifc.start = 1'b0;
    chk({tag, ".done"}, 32'(ifc.done), 32'd1);
    chk({tag, ".idlebusy"}, 32'(ifc.busy), 32'd0);
    chk({tag, ".diff"}, 32'(ifc.diff), 32'(exp_d));
    chk({tag, ".bout"}, 32'(ifc.bout), 32'(exp_bo));
    step();
    chk({tag, ".donepulse"}, 32'(ifc.done), 32'd0);
    chk({tag, ".holddiff"}, 32'(ifc.diff), 32'(exp_d));
  endtask

  initial begin
    logic [W:0] ref9;
    logic [W-1:0] ra, rb;
    logic rbin;

    ifc.start = 1'b0; ifc.a = '0; ifc.b = '0; ifc.bin = 1'b0;

    // Reset state
    step();
    chk("rst.diff", 32'(ifc.diff), 32'd0);
    chk("rst.bout", 32'(ifc.bout), 32'd0);
    chk("rst.busy", 32'(ifc.busy), 32'd0);
    chk("rst.done", 32'(ifc.done), 32'd0);
    #3 rst_n = 1'b1;
    step();

    // Directed vectors
    run_op("v100_37", 8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b0);
    run_op("v0_1",    8'd0,   8'd1,  1'b0, 8'd255, 1'b1, 1'b0);
    run_op("v5_5_1",  8'd5,   8'd5,  1'b1, 8'd255, 1'b1, 1'b0);
    run_op("v200_200", 8'd200, 8'd200, 1'b0, 8'd0, 1'b0, 1'b0);
    run_op("v255_0_1", 8'd255, 8'd0, 1'b1, 8'd254, 1'b0, 1'b0);

    // Start during SHIFT must be ignored
    run_op("ignstart", 8'd10, 8'd3, 1'b0, 8'd7, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("ignstart.nodone", 32'(ifc.done), 32'd0);
      chk("ignstart.nobusy", 32'(ifc.busy), 32'd0);
      chk("ignstart.hold", 32'(ifc.diff), 32'd7);
      step();
    end

    // Reset in the middle of SHIFT aborts the operation
    ifc.a = 8'd77; ifc.b = 8'd11; ifc.bin = 1'b0; ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
    step(); step(); step();
    chk("midrst.busy_before", 32'(ifc.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.diff", 32'(ifc.diff), 32'd0);
    chk("midrst.bout", 32'(ifc.bout), 32'd0);
    chk("midrst.busy", 32'(ifc.busy), 32'd0);
    chk("midrst.done", 32'(ifc.done), 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        #2 rst_n = 1'b1;
      end
      step();
      chk("midrst.nodone", 32'(ifc.done), 32'd0);
    end
    run_op("v9_4", 8'd9, 8'd4, 1'b0, 8'd5, 1'b0, 1'b0);

    // Back-to-back random operations with start held high
    ifc.start = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      ref9 = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      ifc.a = ra; ifc.b = rb; ifc.bin = rbin;
      step();
      ifc.a = W'($urandom); ifc.b = W'($urandom); ifc.bin = 1'($urandom);
      for (int i = 0; i < W; i++) step();
      chk("rnd.done", 32'(ifc.done), 32'd1);
      chk("rnd.diff", 32'(ifc.diff), 32'(ref9[W-1:0]));
      chk("rnd.bout", 32'(ifc.bout), 32'(ref9[W]));
      step();
      chk("rnd.idle", 32'(ifc.busy), 32'd0);
    end
    ifc.start = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
